// File: rtl/vend_controller.sv
// Vending control FSM for the gruel machine.
// Accumulates coin credit in shillings, dispenses one gruel when the credit
// reaches PRICE, then pays change (or a refund) one coin at a time.
// All outputs come straight from registers so they can drive the LED stage.
// Optional feature: define VEND_AUTO_CANCEL_EN to refund the credit
// automatically after TIMEOUT_CYCLES coin-free cycles in COLLECT.
module vend_controller #(
  parameter int PRICE          = 3,
  parameter int CREDIT_W       = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_shilling,
  input  logic                coin_florin,
  input  logic                coin_crown,
  input  logic                cancel,
  output logic [3:0]          state,
  output logic                gruel,
  output logic [2:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    COLLECT  = 4'd1,
    DISPENSE = 4'd2,
    CHANGE   = 4'd3,
    REFUND   = 4'd4
  } state_e;

  // The coin sum needs at least 4 bits (up to 8 shillings in one cycle) even
  // when the credit register itself is narrower.
  localparam int SUM_W  = (CREDIT_W + 1 > 4) ? CREDIT_W + 1 : 4;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [SUM_W-1:0]  PRICE_S      = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]  MAX_CREDIT_S = SUM_W'((1 << CREDIT_W) - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);

  // Reject impossible configurations at elaboration time.
  if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 1) begin : g_bad_price
    $error("vend_controller: PRICE must be within 1..2**CREDIT_W-1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("vend_controller: HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vend_controller: TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                gap_q, gap_d;
  logic                gruel_q, gruel_d;
  logic [2:0]          change_q, change_d;
  logic                reject_q, reject_d;

`ifdef VEND_AUTO_CANCEL_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] timeout_q, timeout_d;
`endif

  logic [3:0]       coin_value;
  logic             coin_any;
  logic [SUM_W-1:0] sum_raw;
  logic             overflow;
  logic [SUM_W-1:0] sum_acc;
  logic             accepted;

  // Largest coin that still fits into the remaining credit.
  function automatic logic [2:0] pick_coin(input logic [CREDIT_W-1:0] c);
    if (int'(c) >= 4) begin
      return 3'b100;
    end else if (int'(c) >= 2) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

  // Shilling value of a one-hot change code.
  function automatic logic [SUM_W-1:0] coin_amount(input logic [2:0] code);
    case (code)
      3'b100:  return SUM_W'(4);
      3'b010:  return SUM_W'(2);
      default: return SUM_W'(1);
    endcase
  endfunction

  // Coin arithmetic shared by IDLE and COLLECT.
  always_comb begin
    coin_value = (coin_shilling ? 4'd1 : 4'd0)
               + (coin_florin   ? 4'd2 : 4'd0)
               + (coin_crown    ? 4'd5 : 4'd0);
    coin_any   = coin_shilling | coin_florin | coin_crown;
    sum_raw    = SUM_W'(credit_q) + SUM_W'(coin_value);
    overflow   = sum_raw > MAX_CREDIT_S;
    // An overflowing cycle rejects every coin, so the credit stays as it was.
    sum_acc    = overflow ? SUM_W'(credit_q) : sum_raw;
    accepted   = coin_any & ~overflow;
  end

  // Next-state and next-output logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    gruel_d  = 1'b0;
    change_d = change_q;
    reject_d = 1'b0;
`ifdef VEND_AUTO_CANCEL_EN
    timeout_d = '0;
`endif

    case (state_q)
      IDLE, COLLECT: begin
        reject_d = overflow;
        hold_d   = '0;
        gap_d    = 1'b0;
        change_d = 3'b000;
        if (sum_acc >= PRICE_S) begin
          // Dispense wins over a simultaneous cancel.
          state_d  = DISPENSE;
          credit_d = CREDIT_W'(sum_acc - PRICE_S);
          gruel_d  = 1'b1;
        end else if (cancel && sum_acc != '0) begin
          // Coins of this cycle are added before the refund starts.
          state_d  = REFUND;
          credit_d = CREDIT_W'(sum_acc);
          change_d = pick_coin(CREDIT_W'(sum_acc));
        end else if (accepted) begin
          state_d  = COLLECT;
          credit_d = CREDIT_W'(sum_acc);
        end else begin
`ifdef VEND_AUTO_CANCEL_EN
          if (state_q == COLLECT) begin
            if (timeout_q == TO_LAST) begin
              state_d  = REFUND;
              change_d = pick_coin(credit_q);
            end else begin
              timeout_d = timeout_q + TO_W'(1);
            end
          end
`endif
        end
      end

      DISPENSE: begin
        reject_d = coin_any;
        change_d = 3'b000;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          gap_d  = 1'b0;
          if (credit_q != '0) begin
            state_d  = CHANGE;
            change_d = pick_coin(credit_q);
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
          gruel_d = 1'b1;
        end
      end

      CHANGE, REFUND: begin
        reject_d = coin_any;
        if (gap_q) begin
          // Gap cycle: change is low; either finish or start the next coin.
          gap_d  = 1'b0;
          hold_d = '0;
          if (credit_q == '0) begin
            state_d = IDLE;
          end else begin
            change_d = pick_coin(credit_q);
          end
        end else if (hold_q == HOLD_LAST) begin
          credit_d = CREDIT_W'(SUM_W'(credit_q) - coin_amount(change_q));
          change_d = 3'b000;
          gap_d    = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        // Unused codes recover to a clean IDLE.
        state_d  = IDLE;
        credit_d = '0;
        hold_d   = '0;
        gap_d    = 1'b0;
        change_d = 3'b000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      hold_q   <= '0;
      gap_q    <= 1'b0;
      gruel_q  <= 1'b0;
      change_q <= 3'b000;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      gruel_q  <= gruel_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

`ifdef VEND_AUTO_CANCEL_EN
  // Counts consecutive coin-free cycles spent in COLLECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  assign state       = state_q;
  assign gruel       = gruel_q;
  assign change      = change_q;
  assign credit      = credit_q;
  assign coin_reject = reject_q;

endmodule
